count_wrap_monitor: RTL and testbench

Downstream consumer of the free-running 2-bit clock counter. It samples the counter value on a valid strobe and checks that each sample is the previous one plus 1 (mod 4). It counts full wraps (3→0) and counts and flags sequence errors. It tracks lock state so the counter's integrity can be observed on board and checked in simulation.

---
 rtl/count_pkg.sv | 8 +
 rtl/sat_counter.sv | 18 +
 rtl/count_wrap_monitor.sv | 76 +++++++
 tb/tb_count_wrap_monitor.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// count_pkg: shared counter width, monitor state encoding and successor function
package count_pkg;
  localparam int CNT_W = 2;
  typedef enum logic [1:0] {IDLE, TRACK, RESYNC} state_t;
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] value);
    return CNT_W'(value + 1'b1);
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: width-parameterised saturating incrementer with synchronous clear
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;
  assign o_count = r_count;
  // clear wins; otherwise increment until all ones, then hold
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_inc && r_count != {W{1'b1}}) r_count <= r_count + 1'b1;
endmodule

// File: rtl/count_wrap_monitor.sv
// count_wrap_monitor: checks a 2-bit counter stream for +1 steps, counts wraps and errors
module count_wrap_monitor
  import count_pkg::*;
#(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cnt_valid,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              clear,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [ERR_W-1:0]  err_count,
  output logic              seq_err
);
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_ref;
  logic              r_locked, r_wrap_pulse, r_seq_err;
  logic [WRAP_W-1:0] r_wrap_count;
  logic              w_match, w_wrap, w_err;
  assign w_match    = cnt_in == next_count(r_ref);
  assign locked     = r_locked;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_count;
  assign seq_err    = r_seq_err;
  // next state plus wrap/error events; IDLE only captures a reference, clear suppresses everything
  always_comb begin
    w_next = r_state;
    w_wrap = 1'b0;
    w_err  = 1'b0;
    if (clear) w_next = IDLE;
    else if (cnt_valid) begin
      if (r_state == IDLE) w_next = TRACK;
      else begin
        w_wrap = w_match && r_ref == CNT_W'(3);
        w_err  = !w_match;
        w_next = w_match ? TRACK : RESYNC;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // reference sample, lock flag, wrap pulse/count and sticky error flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_ref        <= '0;
      r_locked     <= 1'b0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
      r_seq_err    <= 1'b0;
    end else begin
      r_locked     <= w_next == TRACK;
      r_wrap_pulse <= w_wrap;
      if (clear) begin
        r_ref        <= '0;
        r_wrap_count <= '0;
        r_seq_err    <= 1'b0;
      end else begin
        if (cnt_valid) r_ref <= cnt_in;
        if (w_wrap) r_wrap_count <= r_wrap_count + 1'b1;
        if (w_err) r_seq_err <= 1'b1;
      end
    end
  sat_counter #(.W(ERR_W)) u_err (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_inc   (w_err),
    .o_count (err_count)
  );
endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb_count_wrap_monitor: table-driven and sequence checks of count_wrap_monitor
module tb_count_wrap_monitor;
  logic       clk = 0, rst_n = 0, cnt_valid = 0, clear = 0;
  logic [1:0] cnt_in = 0;
  logic       lk, wp, sq, lk_s, wp_s, sq_s;
  logic [7:0] wc;
  logic [3:0] ec;
  logic [1:0] wc_s, ec_s;
  int checks = 0, errors = 0;

  typedef struct {
    logic v; logic [1:0] d; logic c;
    logic lk, wp; logic [7:0] wc; logic [3:0] ec; logic sq;
  } vec_t;
  vec_t tbl[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  count_wrap_monitor u_big (
    .clk(clk), .rst_n(rst_n), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clear(clear),
    .locked(lk), .wrap_pulse(wp), .wrap_count(wc), .err_count(ec), .seq_err(sq)
  );
  count_wrap_monitor #(.WRAP_W(2), .ERR_W(2)) u_small (
    .clk(clk), .rst_n(rst_n), .cnt_valid(cnt_valid), .cnt_in(cnt_in), .clear(clear),
    .locked(lk_s), .wrap_pulse(wp_s), .wrap_count(wc_s), .err_count(ec_s), .seq_err(sq_s)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, a, e);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d, input logic c);
    cnt_valid = v; cnt_in = d; clear = c;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [1:0] d, input logic c, input logic l,
                              input logic p, input logic [7:0] w, input logic [3:0] e, input logic s);
    vec_t r;
    r.v = v; r.d = d; r.c = c; r.lk = l; r.wp = p; r.wc = w; r.ec = e; r.sq = s;
    return r;
  endfunction

  initial begin
    vec_t e;
    logic [1:0] saved;
    int pulses;
    // reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      cnt_valid = 1'($urandom); cnt_in = 2'($urandom); clear = 1'($urandom);
      @(posedge clk); #1;
    end
    chk("rst_locked", {31'd0, lk}, 0);
    chk("rst_wrap_pulse", {31'd0, wp}, 0);
    chk("rst_wrap_count", {24'd0, wc}, 0);
    chk("rst_err_count", {28'd0, ec}, 0);
    chk("rst_seq_err", {31'd0, sq}, 0);
    cnt_valid = 0; clear = 0;
    #3 rst_n = 1;
    @(posedge clk); #1;
    // normal run 0,1,2,3,0,1,2,3,0
    tbl.push_back(mk(1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,1,0, 1,0,0,0,0));
    tbl.push_back(mk(1,2,0, 1,0,0,0,0));
    tbl.push_back(mk(1,3,0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 1,1,1,0,0));
    tbl.push_back(mk(1,1,0, 1,0,1,0,0));
    tbl.push_back(mk(1,2,0, 1,0,1,0,0));
    tbl.push_back(mk(1,3,0, 1,0,1,0,0));
    tbl.push_back(mk(1,0,0, 1,1,2,0,0));
    // clear, then error and resync: 0,1,3,0
    tbl.push_back(mk(0,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1,1,0, 1,0,0,0,0));
    tbl.push_back(mk(1,3,0, 0,0,0,1,1));
    tbl.push_back(mk(1,0,0, 1,1,1,1,1));
    // idle cycle changes nothing
    tbl.push_back(mk(0,3,0, 1,0,1,1,1));
    tbl.push_back(mk(1,1,0, 1,0,1,1,1));
    tbl.push_back(mk(1,2,0, 1,0,1,1,1));
    tbl.push_back(mk(1,3,0, 1,0,1,1,1));
    // clear beats a wrapping sample, then 2 becomes the new reference
    tbl.push_back(mk(1,0,1, 0,0,0,0,0));
    tbl.push_back(mk(1,2,0, 1,0,0,0,0));
    tbl.push_back(mk(1,3,0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,0, 1,1,1,0,0));
    foreach (tbl[i]) begin
      sb.push_back(tbl[i]);
      drive(tbl[i].v, tbl[i].d, tbl[i].c);
      e = sb.pop_front();
      chk($sformatf("row%0d_locked", i), {31'd0, lk}, {31'd0, e.lk});
      chk($sformatf("row%0d_wrap_pulse", i), {31'd0, wp}, {31'd0, e.wp});
      chk($sformatf("row%0d_wrap_count", i), {24'd0, wc}, {24'd0, e.wc});
      chk($sformatf("row%0d_err_count", i), {28'd0, ec}, {28'd0, e.ec});
      chk($sformatf("row%0d_seq_err", i), {31'd0, sq}, {31'd0, e.sq});
    end
    // error saturation: 0 then 2,2,2,2,2 gives 5 mismatches
    drive(0, 0, 1);
    drive(1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 2, 0);
    chk("sat_small_err_count", {30'd0, ec_s}, 3);
    chk("sat_big_err_count", {28'd0, ec}, 5);
    chk("sat_small_seq_err", {31'd0, sq_s}, 1);
    chk("sat_locked", {31'd0, lk}, 0);
    // five wraps with idle cycles between samples
    drive(0, 0, 1);
    drive(1, 0, 0);
    pulses = 0;
    for (int k = 0; k < 5; k++)
      for (int s = 1; s <= 4; s++) begin
        drive(1, 2'(s), 0);
        if (wp_s) pulses++;
        saved = wc_s;
        drive(0, 2'(s + 1), 0);
        chk("idle_wrap_pulse", {31'd0, wp_s}, 0);
        chk("idle_wrap_count", {30'd0, wc_s}, {30'd0, saved});
      end
    chk("roll_pulses", pulses, 5);
    chk("roll_small_wrap_count", {30'd0, wc_s}, 1);
    chk("roll_big_wrap_count", {24'd0, wc}, 5);
    chk("roll_err_count", {28'd0, ec}, 0);
    // asynchronous reset between edges while locked with wrap_count 5
    chk("pre_async_locked", {31'd0, lk}, 1);
    #2 rst_n = 0;
    #1;
    chk("async_locked", {31'd0, lk}, 0);
    chk("async_wrap_count", {24'd0, wc}, 0);
    chk("async_err_count", {28'd0, ec}, 0);
    chk("async_seq_err", {31'd0, sq}, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1;
    @(negedge clk);
    drive(1, 1, 0);
    chk("resume_locked", {31'd0, lk}, 1);
    chk("resume_wrap_count", {24'd0, wc}, 0);
    drive(1, 2, 0);
    chk("resume_err_count", {28'd0, ec}, 0);
    chk("resume_seq_err", {31'd0, sq}, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
